hilo_mdu_ctrl: RTL and testbench



---
 rtl/hilo_mdu_if.sv | 27 ++
 rtl/hilo_mdu_ctrl.sv | 137 +++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/hilo_mdu_if.sv
// Decode-to-MDU handshake and HI/LO write/read-enable bundle.
interface hilo_mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_hi;
  logic             rd_lo;
  logic             busy;
  logic             done;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;
  logic             hi_ena;
  logic             lo_ena;

  modport master (
    output start, op, a, b, rd_hi, rd_lo,
    input  busy, done, hi_write, lo_write, hi_wdata, lo_wdata, hi_ena, lo_ena
  );

  modport slave (
    input  start, op, a, b, rd_hi, rd_lo,
    output busy, done, hi_write, lo_write, hi_wdata, lo_wdata, hi_ena, lo_ena
  );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO writes: one bit per cycle,
// sign fix-up in FIX, results written back in WB.
module hilo_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  hilo_mdu_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d, araw_q, araw_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic               arith_op, sgn_op, div_op;
  logic [WIDTH:0]     msum, dtrial, ddiff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign div_op   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign sgn_op   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign arith_op = div_op || (bus.op == OP_MULT) || (bus.op == OP_MULTU);

  // acc = {hi, lo}: multiply keeps multiplier in lo and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign dtrial  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ddiff   = dtrial - {1'b0, mb_q};
  assign quo_fix = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && arith_op) begin
          ma_d     = (sgn_op && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
          mb_d     = (sgn_op && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
          araw_d   = bus.a;
          is_div_d = div_op;
          neg_d    = sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rneg_d   = sgn_op && bus.a[WIDTH-1];
          dz_d     = div_op && (bus.b == '0);
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, (div_op ? ma_d : mb_d)};
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (!ddiff[WIDTH])
            acc_d = {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        // Divide by zero reports the raw dividend in HI and all-ones in LO.
        if (is_div_q && dz_q)
          acc_d = {araw_q, {WIDTH{1'b1}}};
        else if (is_div_q)
          acc_d = {rem_fix, quo_fix};
        else if (neg_q)
          acc_d = ~acc_q + 1'b1;
        state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  logic idle, wb, mthi, mtlo;
  assign idle = (state_q == S_IDLE) && !rst;
  assign wb   = (state_q == S_WB) && !rst;
  assign mthi = idle && bus.start && (bus.op == OP_MTHI);
  assign mtlo = idle && bus.start && (bus.op == OP_MTLO);

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = wb;
  assign bus.hi_write = wb || mthi;
  assign bus.lo_write = wb || mtlo;
  assign bus.hi_wdata = wb ? acc_q[2*WIDTH-1:WIDTH] : (mthi ? bus.a : '0);
  assign bus.lo_wdata = wb ? acc_q[WIDTH-1:0]       : (mtlo ? bus.a : '0);
  assign bus.hi_ena   = bus.rd_hi && idle;
  assign bus.lo_ena   = bus.rd_lo && idle;
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl with hand-computed HI/LO results.
module tb_hilo_mdu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_mdu_if #(.WIDTH(32)) m ();
  hilo_mdu_ctrl #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call at #1 after an edge in IDLE; returns at #1 after edge T+35.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exph,
                        input logic [31:0] expl, input int inj);
    logic bok;
    m.start = 1'b1; m.op = o; m.a = av; m.b = bv;
    @(posedge clk); #1;
    m.start = 1'b0; m.op = 3'd0; m.a = '0; m.b = '0;
    bok = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      if (m.busy !== 1'b1) bok = 1'b0;
      if (k < 34 && (m.done || m.hi_write || m.lo_write)) bok = 1'b0;
      if (k == inj) begin
        m.start = 1'b1; m.op = 3'd6; m.a = 32'hDEADBEEF; m.rd_lo = 1'b1; m.rd_hi = 1'b1;
        #1;
        chk({tag, "_mtlo_ignored"}, {31'd0, m.lo_write}, 32'd0);
        chk({tag, "_lo_ena_busy"}, {30'd0, m.hi_ena, m.lo_ena}, 32'd0);
      end
      if (k == 34) begin
        chk({tag, "_wb_strobes"}, {29'd0, m.done, m.hi_write, m.lo_write}, 32'd7);
        chk({tag, "_hi"}, m.hi_wdata, exph);
        chk({tag, "_lo"}, m.lo_wdata, expl);
      end
      @(posedge clk); #1;
      if (k == inj) begin
        m.start = 1'b0; m.op = 3'd0; m.a = '0; m.rd_lo = 1'b0; m.rd_hi = 1'b0;
      end
    end
    chk({tag, "_busy34"}, {31'd0, bok}, 32'd1);
    chk({tag, "_idle_after"}, {29'd0, m.busy, m.done, m.hi_write}, 32'd0);
  endtask

  initial begin
    logic bok;
    m.start = 1'b0; m.op = 3'd0; m.a = '0; m.b = '0; m.rd_hi = 1'b0; m.rd_lo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {26'd0, m.busy, m.done, m.hi_write, m.lo_write, m.hi_ena, m.lo_ena}, 32'd0);
    chk("reset_wdata", m.hi_wdata | m.lo_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    // Read enables open again once idle.
    m.rd_hi = 1'b1; m.rd_lo = 1'b1; #1;
    chk("ena_idle", {30'd0, m.hi_ena, m.lo_ena}, 32'd3);
    m.rd_hi = 1'b0; m.rd_lo = 1'b0;
    @(posedge clk); #1;

    run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 0);
    run_op("divu_zero", 3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0);
    run_op("div_zero_neg", 3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);

    // MTHI in IDLE: combinational write, no busy.
    m.start = 1'b1; m.op = 3'd5; m.a = 32'h12345678; #1;
    chk("mthi_strobe", {29'd0, m.hi_write, m.lo_write, m.busy}, 32'd4);
    chk("mthi_data", m.hi_wdata, 32'h12345678);
    m.op = 3'd6; m.a = 32'hCAFEF00D; #1;
    chk("mtlo_strobe", {29'd0, m.hi_write, m.lo_write, m.busy}, 32'd2);
    chk("mtlo_data", m.lo_wdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    m.start = 1'b0; m.op = 3'd0; m.a = '0;
    chk("mt_no_busy", {31'd0, m.busy}, 32'd0);
    m.start = 1'b1; m.op = 3'd7; m.a = 32'hFFFFFFFF; #1;
    chk("reserved_nop", {30'd0, m.hi_write, m.lo_write}, 32'd0);
    @(posedge clk); #1;
    m.start = 1'b0; m.op = 3'd0; m.a = '0;
    chk("reserved_no_busy", {31'd0, m.busy}, 32'd0);

    // MTLO and rd_lo injected at CALC cycle 5 of a MULT.
    run_op("mult_inj", 3'd1, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, 5);

    // Reset during CALC of DIVU aborts without writing.
    m.start = 1'b1; m.op = 3'd4; m.a = 32'd100; m.b = 32'd7;
    @(posedge clk); #1;
    m.start = 1'b0; m.op = 3'd0; m.a = '0; m.b = '0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_rst", {31'd0, m.busy}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_abort", {28'd0, m.busy, m.done, m.hi_write, m.lo_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (m.busy || m.hi_write || m.lo_write || m.done) bok = 1'b0;
    end
    chk("no_write_after_rst", {31'd0, bok}, 32'd1);
    run_op("multu_after_rst", 3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
